// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the line-fetch state type; the sprite
// drawer imports the same bases and line pitch so both sides agree on layout.
package fb_pkg;

  localparam logic [5:0]  LINE_WORDS = 6'd40;
  localparam logic [9:0]  H_ACTIVE   = 10'd640;
  localparam logic [9:0]  V_ACTIVE   = 10'd480;
  localparam logic [9:0]  V_TOTAL    = 10'd525;
  localparam logic [21:0] FB_BASE0   = 22'h100000;
  localparam logic [21:0] FB_BASE1   = 22'h200000;
  localparam logic [7:0]  BLANK_IDX  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_e;

  // line * 40 without a multiplier: (line << 5) + (line << 3)
  function automatic logic [21:0] line_offset(input logic [9:0] line);
    logic [21:0] l;
    l = {12'd0, line};
    return (l << 5) + (l << 3);
  endfunction

endpackage

// File: rtl/line_buf_2x40.sv
// Ping-pong scanline buffer: two banks of 40 x 128-bit words, one write port
// and one registered read port.
module line_buf_2x40
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         wr_en,
  input  logic         wr_bank,
  input  logic [5:0]   wr_word,
  input  logic [127:0] wr_data,
  input  logic         rd_en,
  input  logic         rd_bank,
  input  logic [5:0]   rd_word,
  output logic [127:0] rd_data
);

  logic [127:0] mem [0:79];
  logic [6:0]   wr_idx;
  logic [6:0]   rd_idx;

  // Bank 1 occupies entries 40..79
  assign wr_idx = {1'b0, wr_word} + (wr_bank ? {1'b0, LINE_WORDS} : 7'd0);
  assign rd_idx = {1'b0, rd_word} + (rd_bank ? {1'b0, LINE_WORDS} : 7'd0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/fb_line_fetch.sv
// Display-side line fetcher: pulls the next scanline from the displayed frame
// buffer during hblank and streams 8-bit palette indices during the active line.
module fb_line_fetch
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_ce,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         frame_flip,
  input  logic         sdram_wait,
  input  logic         sdram_rdvalid,
  input  logic [127:0] sdram_rdata,
  output logic         sdram_rd,
  output logic [21:0]  sdram_addr,
  output logic [7:0]   pixel_idx,
  output logic         fetch_busy,
  output logic         underrun
);

  fetch_state_e state, state_nxt;

  logic [5:0]   req_cnt;
  logic [5:0]   ret_cnt;
  logic [5:0]   ret_nxt;
  logic [21:0]  start_addr;
  logic [9:0]   fetch_line;
  logic         disp_sel;
  logic         trigger;
  logic [9:0]   trig_line;
  logic         accept;
  logic         ret_fire;
  logic         line_start;
  logic         active;
  logic         pix_act;
  logic [3:0]   pix_byte;
  logic [127:0] buf_rdata;

  assign line_start = pix_ce && (DrawX == 10'd0);
  assign trigger    = pix_ce && (DrawX == H_ACTIVE) &&
                      ((DrawY < V_ACTIVE - 10'd1) || (DrawY == V_TOTAL - 10'd1));
  assign trig_line  = (DrawY == V_TOTAL - 10'd1) ? 10'd0 : DrawY + 10'd1;

  // Read handshake: a request transfers on every cycle with sdram_rd=1 and
  // sdram_wait=0; while waiting, sdram_addr is held unchanged. Returns carry
  // no handshake and arrive in request order on sdram_rdvalid.
  assign sdram_rd   = (state == REQ);
  assign sdram_addr = (state == REQ) ? start_addr + {16'd0, req_cnt} : '0;
  assign accept     = sdram_rd && !sdram_wait;
  assign ret_fire   = sdram_rdvalid && (state != IDLE) && (ret_cnt != LINE_WORDS);
  assign ret_nxt    = ret_cnt + {5'd0, ret_fire};
  assign fetch_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = REQ;
      end
      REQ: begin
        if (accept && (req_cnt == LINE_WORDS - 6'd1)) begin
          state_nxt = (ret_nxt == LINE_WORDS) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (ret_nxt == LINE_WORDS) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_cnt    <= '0;
      ret_cnt    <= '0;
      start_addr <= '0;
      fetch_line <= '0;
      disp_sel   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && trigger) begin
        start_addr <= (disp_sel ? FB_BASE1 : FB_BASE0) + line_offset(trig_line);
        fetch_line <= trig_line;
        req_cnt    <= '0;
        ret_cnt    <= '0;
      end else begin
        if (accept)   req_cnt <= req_cnt + 6'd1;
        if (ret_fire) ret_cnt <= ret_nxt;
      end
      // Display the buffer opposite to the one the drawer is filling
      if (line_start && (DrawY == V_ACTIVE)) begin
        disp_sel <= ~frame_flip;
      end
      if ((trigger && (state != IDLE)) ||
          (line_start && (DrawY < V_ACTIVE) && (state != IDLE) && (fetch_line == DrawY))) begin
        underrun <= 1'b1;
      end
    end
  end

  assign active = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE);

  line_buf_2x40 u_line_buf (
    .clk     (clk),
    .wr_en   (ret_fire),
    .wr_bank (fetch_line[0]),
    .wr_word (ret_cnt),
    .wr_data (sdram_rdata),
    .rd_en   (pix_ce && active),
    .rd_bank (DrawY[0]),
    .rd_word (DrawX[9:4]),
    .rd_data (buf_rdata)
  );

  // Two pix_ce stages: buffer read, then byte select into pixel_idx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_act   <= 1'b0;
      pix_byte  <= '0;
      pixel_idx <= BLANK_IDX;
    end else if (pix_ce) begin
      pix_act   <= active;
      pix_byte  <= DrawX[3:0];
      pixel_idx <= pix_act ? buf_rdata[{pix_byte, 3'b000} +: 8] : BLANK_IDX;
    end
  end

endmodule

// File: tb/tb_fb_line_fetch.sv
// Self-checking bench for fb_line_fetch: SDRAM model with fixed read latency,
// address and pixel scoreboards, and one task per scenario.
module tb_fb_line_fetch;
  import fb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         pix_ce;
  logic [9:0]   DrawX;
  logic [9:0]   DrawY;
  logic         frame_flip;
  logic         sdram_wait = 1'b0;
  logic         sdram_rdvalid = 1'b0;
  logic [127:0] sdram_rdata = '0;
  logic         sdram_rd;
  logic [21:0]  sdram_addr;
  logic [7:0]   pixel_idx;
  logic         fetch_busy;
  logic         underrun;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fb_line_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .pix_ce        (pix_ce),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .frame_flip    (frame_flip),
    .sdram_wait    (sdram_wait),
    .sdram_rdvalid (sdram_rdvalid),
    .sdram_rdata   (sdram_rdata),
    .sdram_rd      (sdram_rd),
    .sdram_addr    (sdram_addr),
    .pixel_idx     (pixel_idx),
    .fetch_busy    (fetch_busy),
    .underrun      (underrun)
  );

  // ---------------- SDRAM model (3-clk read latency) and monitors ----------
  int          wait_mode = 0;  // 0 never wait, 1 toggle, 2 always wait
  logic        w = 1'b0;
  logic        pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  logic [21:0] pa0 = '0, pa1 = '0, pa2 = '0;
  logic [21:0] acc_q[$];
  logic [21:0] exp_q[$];
  logic [7:0]  pix_q[$];
  int          busy_cnt = 0;
  int          hold_err = 0;
  logic        prev_wait_req = 1'b0;
  logic [21:0] prev_addr = '0;

  // Byte k of word a is (a*16 + k) mod 256, so pixel (x,y) reads (y*640+x) mod 256
  function automatic logic [127:0] word_data(input logic [21:0] a);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = {a[3:0], 4'(k)};
    return d;
  endfunction

  function automatic logic [7:0] exp_pix(input int x, input int y);
    if (x < 640 && y < 480) return 8'(y * 640 + x);
    return BLANK_IDX;
  endfunction

  always @(negedge clk) begin
    sdram_rdvalid = pv2;
    sdram_rdata   = pv2 ? word_data(pa2) : '0;
    pv2 = pv1; pa2 = pa1;
    pv1 = pv0; pa1 = pa0;
    case (wait_mode)
      0:       w = 1'b0;
      1:       w = ~w;
      default: w = 1'b1;
    endcase
    sdram_wait = w;
    pv0 = sdram_rd & ~w & reset;
    pa0 = sdram_addr;
    if (pv0) acc_q.push_back(sdram_addr);
    if (prev_wait_req && sdram_rd && (sdram_addr !== prev_addr)) hold_err++;
    prev_wait_req = sdram_rd & w;
    prev_addr     = sdram_addr;
    if (fetch_busy) busy_cnt++;
  end

  // ---------------- driver tasks ------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    tick();
  endtask

  task automatic push_line(input logic [21:0] base, input int line);
    for (int i = 0; i < 40; i++) exp_q.push_back(base + 22'(line * 40 + i));
  endtask

  task automatic wait_fetch_done(input string name, input int budget);
    int n;
    n = 0;
    while (fetch_busy && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (fetch_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_timeout: fetch_busy=%0b after %0d cycles, want 0", name, fetch_busy, n);
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    reset = 1'b0; pix_ce = 1'b0; DrawX = '0; DrawY = '0; frame_flip = 1'b0;
    repeat (3) tick();
    tests_run += 5;
    if (sdram_rd !== 1'b0) begin tests_failed++; $display("FAIL rst_rd: got %0b want 0", sdram_rd); end
    if (sdram_addr !== 22'd0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", sdram_addr); end
    if (pixel_idx !== BLANK_IDX) begin tests_failed++; $display("FAIL rst_pix: got %h want %h", pixel_idx, BLANK_IDX); end
    if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b want 0", fetch_busy); end
    if (underrun !== 1'b0) begin tests_failed++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
    reset = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_busy: got %0b want 0", fetch_busy); end
  endtask

  task automatic check_addr_seq(input string name);
    logic [21:0] e, a;
    int bad;
    bad = 0;
    while (exp_q.size() > 0 && acc_q.size() > 0) begin
      e = exp_q.pop_front();
      a = acc_q.pop_front();
      if (a !== e) begin
        if (bad == 0) $display("FAIL %s_addr: got %h want %h", name, a, e);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0 || exp_q.size() != 0 || acc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_seq: %0d wrong, %0d missing, %0d extra", name, bad, exp_q.size(), acc_q.size());
    end
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic test_single_fetch();
    frame_flip = 1'b0;
    pix(0, 480);
    acc_q.delete(); exp_q.delete();
    push_line(FB_BASE1, 10);
    busy_cnt = 0;
    pix(640, 9);
    tests_run += 2;
    if (fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %0b want 1", fetch_busy); end
    if (sdram_rd !== 1'b1) begin tests_failed++; $display("FAIL single_rd: got %0b want 1", sdram_rd); end
    wait_fetch_done("single", 200);
    check_addr_seq("single");
    tests_run++;
    if (busy_cnt != 43) begin tests_failed++; $display("FAIL single_busy_len: got %0d cycles want 43", busy_cnt); end
  endtask

  task automatic test_pixel_readout();
    int xs[20];
    logic [7:0] e;
    for (int i = 0; i < 16; i++) xs[i] = i;
    xs[16] = 100; xs[17] = 255; xs[18] = 639; xs[19] = 640;
    pix_q.delete();
    for (int i = 0; i < 21; i++) begin
      int x;
      x = (i < 20) ? xs[i] : 700;
      pix_q.push_back(exp_pix(x, 10));
      pix(x, 10);
      if (pix_q.size() > 1) begin
        e = pix_q.pop_front();
        tests_run++;
        if (pixel_idx !== e) begin
          tests_failed++;
          $display("FAIL pix_line10[%0d]: got %h want %h", i - 1, pixel_idx, e);
        end
      end
    end
    pix_q.delete();
    wait_fetch_done("pix_next_line", 200);
    acc_q.delete();
  endtask

  task automatic test_backpressure();
    acc_q.delete(); exp_q.delete();
    hold_err = 0;
    wait_mode = 1;
    push_line(FB_BASE1, 20);
    pix(640, 19);
    wait_fetch_done("bp", 400);
    wait_mode = 0;
    check_addr_seq("bp");
    tests_run++;
    if (hold_err != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d address changes while waiting want 0", hold_err); end
  endtask

  task automatic test_wrap();
    int ys[4] = '{479, 480, 500, 523};
    logic [7:0] e;
    frame_flip = 1'b1;
    pix(0, 480);
    acc_q.delete(); exp_q.delete();
    foreach (ys[i]) begin
      pix(640, ys[i]);
      tests_run++;
      if (fetch_busy !== 1'b0 || acc_q.size() != 0) begin
        tests_failed++;
        $display("FAIL no_trig_y%0d: busy=%0b reqs=%0d want 0/0", ys[i], fetch_busy, acc_q.size());
      end
    end
    push_line(FB_BASE0, 0);
    pix(640, 524);
    wait_fetch_done("wrap", 200);
    check_addr_seq("wrap");
    pix_q.delete();
    for (int x = 16; x <= 32; x++) begin
      int xx;
      xx = (x == 32) ? 700 : x;
      pix_q.push_back(exp_pix(xx, 0));
      pix(xx, 0);
      if (pix_q.size() > 1) begin
        e = pix_q.pop_front();
        tests_run++;
        if (pixel_idx !== e) begin tests_failed++; $display("FAIL pix_line0_x%0d: got %h want %h", x - 1, pixel_idx, e); end
      end
    end
    pix_q.delete();
  endtask

  task automatic test_underrun();
    acc_q.delete(); exp_q.delete();
    wait_mode = 2;
    tests_run++;
    if (underrun !== 1'b0) begin tests_failed++; $display("FAIL ur_pre: got %0b want 0", underrun); end
    pix(640, 29);
    pix(0, 30);
    tests_run++;
    if (underrun !== 1'b1) begin tests_failed++; $display("FAIL ur_set: got %0b want 1", underrun); end
    pix(640, 30);
    tests_run += 3;
    if (fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL ur_busy: got %0b want 1", fetch_busy); end
    if (sdram_rd !== 1'b1) begin tests_failed++; $display("FAIL ur_rd: got %0b want 1", sdram_rd); end
    if (sdram_addr !== FB_BASE0 + 22'd1200) begin
      tests_failed++; $display("FAIL ur_addr: got %h want %h", sdram_addr, FB_BASE0 + 22'd1200);
    end
    wait_mode = 0;
    push_line(FB_BASE0, 30);
    wait_fetch_done("ur", 200);
    check_addr_seq("ur");
    tests_run++;
    if (underrun !== 1'b1) begin tests_failed++; $display("FAIL ur_sticky: got %0b want 1", underrun); end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    int xs[5] = '{0, 17, 300, 639, 700};
    logic [7:0] e;
    acc_q.delete(); exp_q.delete();
    wait_mode = 0;
    pix(640, 39);
    n = 0;
    while (acc_q.size() < 20 && n < 100) begin tick(); n++; end
    tests_run++;
    if (acc_q.size() != 20) begin tests_failed++; $display("FAIL rmf_reach20: got %0d accepts want 20", acc_q.size()); end
    reset = 1'b0;
    #1;
    tests_run += 4;
    if (sdram_rd !== 1'b0) begin tests_failed++; $display("FAIL rmf_rd: got %0b want 0", sdram_rd); end
    if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rmf_busy: got %0b want 0", fetch_busy); end
    if (sdram_addr !== 22'd0) begin tests_failed++; $display("FAIL rmf_addr: got %h want 0", sdram_addr); end
    if (underrun !== 1'b0) begin tests_failed++; $display("FAIL rmf_underrun: got %0b want 0", underrun); end
    tick();
    reset = 1'b1;
    repeat (6) tick();
    tests_run++;
    if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rmf_stale_rdvalid: busy=%0b want 0", fetch_busy); end
    acc_q.delete(); exp_q.delete();
    push_line(FB_BASE0, 40);
    pix(640, 39);
    wait_fetch_done("rmf", 200);
    check_addr_seq("rmf");
    pix_q.delete();
    foreach (xs[i]) begin
      pix_q.push_back(exp_pix(xs[i], 40));
      pix(xs[i], 40);
      if (pix_q.size() > 1) begin
        e = pix_q.pop_front();
        tests_run++;
        if (pixel_idx !== e) begin tests_failed++; $display("FAIL pix_line40_x%0d: got %h want %h", xs[i - 1], pixel_idx, e); end
      end
    end
    pix_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_pixel_readout();
    test_backpressure();
    test_wrap();
    test_underrun();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
